// File: rtl/alu_seq_if.sv
// Operand/opcode load bus and result handshake for alu_seq.
//   master : drives start, acc_mode, abort, din, din_valid, result_ready
//   slave  : drives din_ready, result, carry, zero, result_valid, busy, curstate
interface alu_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic             acc_mode;
  logic             abort;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic [2:0]       curstate;

  modport master (
    output start, acc_mode, abort, din, din_valid, result_ready,
    input  din_ready, result, carry, zero, result_valid, busy, curstate
  );

  modport slave (
    input  start, acc_mode, abort, din, din_valid, result_ready,
    output din_ready, result, carry, zero, result_valid, busy, curstate
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: loads operand A, operand B and a 3-bit opcode over a
// valid/ready word bus, executes in one cycle and holds the registered
// result until the consumer accepts it.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : alu_seq_if slave modport (load bus, result handshake, status)
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    EXEC    = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic             acc_q, carry_q, zero_q;
  logic             din_ready_q, result_valid_q, busy_q;
  logic             xfer;
  logic [WIDTH:0]   alu_w;

  // Returns {carry, result}. Arithmetic runs in WIDTH+1 bits so the top bit
  // is the carry of a sum or the borrow of a difference taken modulo 2^(WIDTH+1).
  function automatic logic [WIDTH:0] alu_calc(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0] ax, bx, cx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    cx = {{WIDTH{1'b0}}, cin};
    case (op)
      3'd0:    alu_calc = ax + bx;
      3'd1:    alu_calc = ax - bx;
      3'd2:    alu_calc = ax + bx + cx;
      3'd3:    alu_calc = ax - bx - cx;
      3'd4:    alu_calc = {1'b0, a & b};
      3'd5:    alu_calc = {1'b0, a | b};
      3'd6:    alu_calc = {1'b0, a ^ b};
      default: alu_calc = {1'b0, b};
    endcase
  endfunction

  // din_ready_q is high exactly in the load states, so this is the transfer.
  assign xfer  = bus.din_valid && din_ready_q;
  // Accumulate mode feeds the previous result back as operand A.
  assign alu_w = alu_calc(op_q, acc_q ? result_q : a_q, b_q, carry_q);

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = bus.acc_mode ? LOAD_B : LOAD_A;
        LOAD_A:  if (xfer) state_d = LOAD_B;
        LOAD_B:  if (xfer) state_d = LOAD_OP;
        LOAD_OP: if (xfer) state_d = EXEC;
        EXEC:    state_d = DONE;
        DONE:    if (bus.result_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      acc_q          <= 1'b0;
      result_q       <= '0;
      carry_q        <= 1'b0;
      zero_q         <= 1'b0;
      din_ready_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      // Status outputs are registered from the next state so they line up
      // with state_q on the following cycle.
      din_ready_q    <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == LOAD_OP);
      result_valid_q <= (state_d == DONE);
      busy_q         <= (state_d != IDLE);

      if (state_q == IDLE && bus.start) acc_q <= bus.acc_mode;

      if (xfer && !bus.abort) begin
        case (state_q)
          LOAD_A:  a_q  <= bus.din;
          LOAD_B:  b_q  <= bus.din;
          LOAD_OP: op_q <= bus.din[2:0];
          default: ;
        endcase
      end

      // An abort landing on EXEC discards the computation.
      if (state_q == EXEC && !bus.abort) begin
        result_q <= alu_w[WIDTH-1:0];
        carry_q  <= alu_w[WIDTH];
        zero_q   <= (alu_w[WIDTH-1:0] == '0);
      end
    end
  end

  assign bus.din_ready    = din_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.curstate     = state_q;
  assign bus.result       = result_q;
  assign bus.carry        = carry_q;
  assign bus.zero         = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_seq_if #(.WIDTH(4)) bus ();

  alu_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       acc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] exp_res;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    bus.start    = 1'b1;
    bus.acc_mode = v.acc;
    step();
    bus.start    = 1'b0;
    bus.acc_mode = 1'b0;  // later changes must not matter
    chk($sformatf("v%0d_load_state", idx), bus.curstate, v.acc ? 2 : 1);
    bus.din_valid = 1'b1;
    if (!v.acc) begin
      bus.din = v.a;
      step();
    end
    bus.din = v.b;
    step();
    bus.din = v.op;
    step();
    bus.din_valid = 1'b0;
    bus.din       = 4'h0;
    chk($sformatf("v%0d_exec_no_valid", idx), bus.result_valid, 0);
    step();
    chk($sformatf("v%0d_valid", idx), bus.result_valid, 1);
    chk($sformatf("v%0d_result", idx), bus.result, v.exp_res);
    chk($sformatf("v%0d_carry", idx), bus.carry, v.exp_c);
    chk($sformatf("v%0d_zero", idx), bus.zero, v.exp_z);
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    chk($sformatf("v%0d_idle", idx), bus.curstate, 0);
  endtask

  // Drives a non-accumulate operation up to the point where the FSM sits in EXEC.
  task automatic load_to_exec(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bus.start = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = a;
    step();
    bus.din = b;
    step();
    bus.din = op;
    step();
    bus.din_valid = 1'b0;
    bus.din       = 4'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.start        = 1'b0;
    bus.acc_mode     = 1'b0;
    bus.abort        = 1'b0;
    bus.din          = 4'h0;
    bus.din_valid    = 1'b0;
    bus.result_ready = 1'b0;

    // Sequential vectors: carry flows from one entry into the next.
    vecs[0]  = '{1'b0, 4'h7, 4'h5, 4'h0, 4'hC, 1'b0, 1'b0}; // ADD
    vecs[1]  = '{1'b0, 4'h3, 4'h5, 4'h1, 4'hE, 1'b1, 1'b0}; // SUB borrow
    vecs[2]  = '{1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1}; // ADD overflow
    vecs[3]  = '{1'b1, 4'h0, 4'h2, 4'h2, 4'h3, 1'b0, 1'b0}; // acc ADC 0+2+1
    vecs[4]  = '{1'b0, 4'h2, 4'h3, 4'h1, 4'hF, 1'b1, 1'b0}; // SUB 2-3
    vecs[5]  = '{1'b0, 4'h8, 4'h3, 4'h3, 4'h4, 1'b0, 1'b0}; // SBC 8-3-1
    vecs[6]  = '{1'b0, 4'h3, 4'h3, 4'h3, 4'h0, 1'b0, 1'b1}; // SBC 3-3-0
    vecs[7]  = '{1'b0, 4'h0, 4'h1, 4'h1, 4'hF, 1'b1, 1'b0}; // SUB 0-1
    vecs[8]  = '{1'b0, 4'hC, 4'hA, 4'h4, 4'h8, 1'b0, 1'b0}; // AND clears carry
    vecs[9]  = '{1'b0, 4'h0, 4'h1, 4'h1, 4'hF, 1'b1, 1'b0}; // SUB 0-1
    vecs[10] = '{1'b0, 4'hC, 4'hC, 4'h6, 4'h0, 1'b0, 1'b1}; // XOR zero
    vecs[11] = '{1'b0, 4'hC, 4'hA, 4'h5, 4'hE, 1'b0, 1'b0}; // OR
    vecs[12] = '{1'b0, 4'h5, 4'h9, 4'hF, 4'h9, 1'b0, 1'b0}; // PASSB, upper op bits set
    vecs[13] = '{1'b1, 4'h0, 4'h3, 4'h0, 4'hC, 1'b0, 1'b0}; // acc ADD 9+3
    vecs[14] = '{1'b1, 4'h0, 4'h5, 4'h0, 4'h1, 1'b1, 1'b0}; // acc ADD C+5
    vecs[15] = '{1'b1, 4'h0, 4'h1, 4'h3, 4'hF, 1'b1, 1'b0}; // acc SBC 1-1-1

    // Reset, with start also held high to show reset wins.
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rst_curstate", bus.curstate, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_din_ready", bus.din_ready, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_zero", bus.zero, 0);
    step();
    chk("idle_hold", bus.curstate, 0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Backpressure on the load bus and on the result handshake.
    bus.start = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = 4'h7;
    step();
    bus.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_loadb_hold%0d", i), bus.curstate, 2);
      chk($sformatf("bp_loadb_ready%0d", i), bus.din_ready, 1);
    end
    bus.din_valid = 1'b1;
    bus.din       = 4'h5;
    step();
    bus.din = 4'h0;
    step();
    chk("bp_exec", bus.curstate, 4);
    bus.din = 4'h9;  // din_valid still high in EXEC: must be ignored
    step();
    bus.din_valid = 1'b0;
    bus.din       = 4'h0;
    bus.start     = 1'b1;  // start is ignored in DONE
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_done_hold%0d", i), bus.curstate, 5);
      chk($sformatf("bp_done_valid%0d", i), bus.result_valid, 1);
      chk($sformatf("bp_done_din_ready%0d", i), bus.din_ready, 0);
      chk($sformatf("bp_done_result%0d", i), bus.result, 12);
      step();
    end
    bus.start        = 1'b0;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    chk("bp_idle", bus.curstate, 0);
    chk("bp_valid_drop", bus.result_valid, 0);
    chk("bp_carry", bus.carry, 0);

    // Abort in LOAD_OP, coinciding with an opcode transfer and result_ready.
    bus.start = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = 4'h1;
    step();
    bus.din = 4'h2;
    step();
    chk("ab_loadop", bus.curstate, 3);
    bus.din          = 4'h0;
    bus.abort        = 1'b1;
    bus.result_ready = 1'b1;
    step();
    bus.abort        = 1'b0;
    bus.din_valid    = 1'b0;
    bus.result_ready = 1'b0;
    chk("ab_idle", bus.curstate, 0);
    chk("ab_busy", bus.busy, 0);
    chk("ab_result", bus.result, 12);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ab_no_valid%0d", i), bus.result_valid, 0);
      step();
    end

    // Abort landing on EXEC leaves the result registers alone.
    load_to_exec(4'h1, 4'h1, 4'h0);
    chk("abx_exec", bus.curstate, 4);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abx_idle", bus.curstate, 0);
    chk("abx_result", bus.result, 12);
    chk("abx_zero", bus.zero, 0);
    chk("abx_valid", bus.result_valid, 0);

    // Reset in EXEC, together with abort.
    load_to_exec(4'h3, 4'h4, 4'h0);
    chk("rx_exec", bus.curstate, 4);
    reset     = 1'b1;
    bus.abort = 1'b1;
    step();
    reset     = 1'b0;
    bus.abort = 1'b0;
    chk("rx_curstate", bus.curstate, 0);
    chk("rx_result", bus.result, 0);
    chk("rx_carry", bus.carry, 0);
    chk("rx_zero", bus.zero, 0);
    chk("rx_busy", bus.busy, 0);
    chk("rx_din_ready", bus.din_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
